write_back_buffer: RTL and testbench

- Decoupling FIFO between the data cache's eviction port and data_mem's block-write port.
- Accepts evicted dirty 128-bit lines (address plus data) in one cycle and drains them to memory via a req/ack handshake, so the cache never stalls on a writeback unless the buffer is full.
- Coalesces repeated evictions of the same line.
- Serves cache refills of lines still pending in the buffer (lookup port), so memory is never read stale.

---
 rtl/wbb_pkg.sv | 20 ++
 rtl/wbb_match.sv | 41 ++++
 rtl/write_back_buffer.sv | 166 ++++++++++++++++
 tb/tb_write_back_buffer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbb_pkg.sv
// Shared types for the write-back buffer: entry layout, drain FSM states and
// the line-offset width that all tag compares strip from addresses.
package wbb_pkg;
    localparam int WBB_DATA_WIDTH   = 32;
    localparam int WBB_LINE_WIDTH   = 128;
    localparam int LINE_OFFSET_BITS = 4;

    typedef logic [WBB_LINE_WIDTH-1:0] line_t;

    typedef struct packed {
        logic                                     valid;
        logic [WBB_DATA_WIDTH-1:LINE_OFFSET_BITS] tag;
        line_t                                    data;
    } wbb_entry_t;

    typedef enum logic {
        WBB_IDLE,
        WBB_REQ
    } wbb_state_t;
endpackage

// File: rtl/wbb_match.sv
// DEPTH-way tag compare; when several entries match, the one written most
// recently (closest behind the write pointer) is selected.
module wbb_match
    import wbb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 28
) (
    input  logic [DEPTH-1:0]                   valid,
    input  logic [DEPTH-1:0][TAG_W-1:0]        tags,
    input  logic [TAG_W-1:0]                   key,
    input  logic [$clog2(DEPTH)-1:0]           wr_ptr,
    output logic                               hit,
    output logic [$clog2(DEPTH)-1:0]           idx
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] match;
    logic [PTR_W-1:0] slot;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign match[gi] = valid[gi] && (tags[gi] == key);
        end
    endgenerate

    // Walk from oldest (wr_ptr - DEPTH) to youngest (wr_ptr - 1); last match wins.
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        slot = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            slot = wr_ptr - PTR_W'(k);
            if (match[slot]) begin
                hit = 1'b1;
                idx = slot;
            end
        end
    end
endmodule

// File: rtl/write_back_buffer.sv
// Write-back buffer between the data cache eviction port and data_mem: a
// coalescing circular FIFO drained by a req/ack FSM, with a refill lookup port.
module write_back_buffer
    import wbb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_addr,
    input  logic [LINE_WIDTH-1:0]      in_data,
    input  logic [DATA_WIDTH-1:0]      lookup_addr,
    output logic                       lookup_hit,
    output logic [LINE_WIDTH-1:0]      lookup_data,
    output logic                       mem_wr_req,
    input  logic                       mem_wr_ack,
    output logic [DATA_WIDTH-1:0]      mem_wr_addr,
    output logic [LINE_WIDTH-1:0]      mem_wr_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TAG_W = DATA_WIDTH - LINE_OFFSET_BITS;

    logic [DEPTH-1:0]            valid_reg;
    logic [DEPTH-1:0][TAG_W-1:0] tag_reg;
    logic [LINE_WIDTH-1:0]       data_reg [DEPTH];
    logic [PTR_W-1:0]            wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
    logic [CNT_W-1:0]            count_reg;

    wbb_state_t                  state_reg, state_next;
    logic [TAG_W-1:0]            wr_tag_reg, wr_tag_next;
    logic [LINE_WIDTH-1:0]       wr_data_reg, wr_data_next;

    logic [TAG_W-1:0]            in_tag, lookup_tag;
    logic [DEPTH-1:0]            head_mask, coal_valid;
    logic                        co_hit, lk_hit;
    logic [PTR_W-1:0]            co_idx, lk_idx, wr_idx;
    logic                        enq, append, pop;
    logic                        unused_offset;

    assign in_tag        = in_addr[DATA_WIDTH-1:LINE_OFFSET_BITS];
    assign lookup_tag    = lookup_addr[DATA_WIDTH-1:LINE_OFFSET_BITS];
    assign unused_offset = ^{in_addr[LINE_OFFSET_BITS-1:0], lookup_addr[LINE_OFFSET_BITS-1:0]};

    // The head is either in flight or being latched this edge, so it never absorbs a coalesce.
    assign head_mask  = DEPTH'(1) << rd_ptr_reg;
    assign coal_valid = valid_reg & ~head_mask;

    wbb_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_coal_match (
        .valid  (coal_valid),
        .tags   (tag_reg),
        .key    (in_tag),
        .wr_ptr (wr_ptr_reg),
        .hit    (co_hit),
        .idx    (co_idx)
    );

    wbb_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_lookup_match (
        .valid  (valid_reg),
        .tags   (tag_reg),
        .key    (lookup_tag),
        .wr_ptr (wr_ptr_reg),
        .hit    (lk_hit),
        .idx    (lk_idx)
    );

    assign full       = (count_reg == CNT_W'(DEPTH));
    assign empty      = (count_reg == '0);
    assign count      = count_reg;
    assign in_ready   = !full || co_hit;
    assign enq        = in_valid && in_ready;
    assign append     = enq && !co_hit;
    assign pop        = (state_reg == WBB_REQ) && mem_wr_ack;
    assign wr_idx     = co_hit ? co_idx : wr_ptr_reg;
    assign rd_ptr_inc = rd_ptr_reg + PTR_W'(1);

    assign lookup_hit  = lk_hit;
    assign lookup_data = lk_hit ? data_reg[lk_idx] : '0;

    assign mem_wr_req  = (state_reg == WBB_REQ);
    assign mem_wr_addr = {wr_tag_reg, {LINE_OFFSET_BITS{1'b0}}};
    assign mem_wr_data = wr_data_reg;

    always_ff @(posedge clk) begin
        if (enq) begin
            data_reg[wr_idx] <= in_data;
        end
        if (append) begin
            tag_reg[wr_ptr_reg] <= in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (append) begin
                valid_reg[wr_ptr_reg] <= 1'b1;
                wr_ptr_reg            <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                valid_reg[rd_ptr_reg] <= 1'b0;
                rd_ptr_reg            <= rd_ptr_inc;
            end
            count_reg <= count_reg + CNT_W'(append) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= WBB_IDLE;
            wr_tag_reg  <= '0;
            wr_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            wr_tag_reg  <= wr_tag_next;
            wr_data_reg <= wr_data_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        wr_tag_next  = wr_tag_reg;
        wr_data_next = wr_data_reg;
        case (state_reg)
            WBB_IDLE: begin
                if (!empty) begin
                    wr_tag_next  = tag_reg[rd_ptr_reg];
                    wr_data_next = data_reg[rd_ptr_reg];
                    state_next   = WBB_REQ;
                end else if (enq) begin
                    // Empty buffer: the arriving line becomes the head directly.
                    wr_tag_next  = in_tag;
                    wr_data_next = in_data;
                    state_next   = WBB_REQ;
                end
            end
            WBB_REQ: begin
                if (mem_wr_ack) begin
                    if (count_reg > CNT_W'(1)) begin
                        // Forward a same-edge coalesce into the next head so it is not lost.
                        wr_tag_next  = tag_reg[rd_ptr_inc];
                        wr_data_next = (co_hit && enq && (co_idx == rd_ptr_inc))
                                       ? in_data : data_reg[rd_ptr_inc];
                    end else if (enq) begin
                        wr_tag_next  = in_tag;
                        wr_data_next = in_data;
                    end else begin
                        state_next = WBB_IDLE;
                    end
                end
            end
            default: state_next = WBB_IDLE;
        endcase
    end
endmodule

// File: tb/tb_write_back_buffer.sv
// Directed bench for write_back_buffer: a queue model of the buffer is checked
// against the DUT every cycle, plus literal expectations per scenario.
module tb_write_back_buffer;
    localparam int DW    = 32;
    localparam int LW    = 128;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_addr = '0;
    logic [LW-1:0] in_data = '0;
    logic [DW-1:0] lookup_addr = '0;
    logic          lookup_hit;
    logic [LW-1:0] lookup_data;
    logic          mem_wr_req;
    logic          mem_wr_ack = 1'b0;
    logic [DW-1:0] mem_wr_addr;
    logic [LW-1:0] mem_wr_data;
    logic [2:0]    count;
    logic          empty, full;

    int total = 0;
    int bad   = 0;

    logic [27:0]   m_tag[$];
    logic [LW-1:0] m_data[$];
    logic [DW-1:0] log_addr[$];
    logic [LW-1:0] log_data[$];

    always #5 clk = ~clk;

    write_back_buffer #(.DATA_WIDTH(DW), .LINE_WIDTH(LW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .lookup_addr (lookup_addr),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data),
        .mem_wr_req  (mem_wr_req),
        .mem_wr_ack  (mem_wr_ack),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .count       (count),
        .empty       (empty),
        .full        (full)
    );

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Youngest queue position at or after 'from' holding the line, -1 if none.
    function automatic int find_young(input logic [27:0] t, input int from);
        int r = -1;
        for (int i = from; i < m_tag.size(); i++)
            if (m_tag[i] == t) r = i;
        return r;
    endfunction

    always @(negedge rst_n) begin
        m_tag.delete();
        m_data.delete();
    end

    // Model: buffer is a queue, q[0] is being written whenever the queue is non-empty.
    always @(posedge clk) begin
        if (rst_n) begin
            int  ci;
            bit  rdy, enq, pop;
            ci  = find_young(in_addr[31:4], 1);
            rdy = (m_tag.size() < DEPTH) || (ci >= 0);
            enq = in_valid && rdy;
            pop = mem_wr_ack && (m_tag.size() > 0);
            if (enq) begin
                if (ci >= 0) m_data[ci] = in_data;
                else begin
                    m_tag.push_back(in_addr[31:4]);
                    m_data.push_back(in_data);
                end
            end
            if (pop) begin
                void'(m_tag.pop_front());
                void'(m_data.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && mem_wr_req && mem_wr_ack) begin
            log_addr.push_back(mem_wr_addr);
            log_data.push_back(mem_wr_data);
            $display("write addr=%h data=%h", mem_wr_addr, mem_wr_data);
        end
    end

    always @(negedge clk) begin
        int li;
        bit exp_ready;
        exp_ready = (m_tag.size() < DEPTH) || (find_young(in_addr[31:4], 1) >= 0);
        li = find_young(lookup_addr[31:4], 0);
        chk("m_in_ready", LW'(in_ready), LW'(exp_ready));
        chk("m_count", LW'(count), LW'(m_tag.size()));
        chk("m_empty", LW'(empty), LW'(m_tag.size() == 0));
        chk("m_full", LW'(full), LW'(m_tag.size() == DEPTH));
        chk("m_req", LW'(mem_wr_req), LW'(m_tag.size() > 0));
        if (m_tag.size() > 0) begin
            chk("m_wr_addr", LW'(mem_wr_addr), LW'({m_tag[0], 4'h0}));
            chk("m_wr_data", mem_wr_data, m_data[0]);
        end
        chk("m_lk_hit", LW'(lookup_hit), LW'(li >= 0));
        chk("m_lk_data", lookup_data, (li >= 0) ? m_data[li] : '0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic evict(input logic [DW-1:0] a, input logic [LW-1:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LW-1:0] aa, d0, d1, d2, d2n, d3, e1, e2, f;
        int b;
        aa  = {4{32'hAAAA_AAAA}};
        d0  = {4{32'h0000_0D00}};
        d1  = {4{32'h0000_0D01}};
        d2  = {4{32'h0000_0D02}};
        d2n = {4{32'h0000_2D2D}};
        d3  = {4{32'h0000_0D03}};
        e1  = {4{32'hE1E1_0001}};
        e2  = {4{32'hE2E2_0002}};
        f   = {4{32'hF00D_CAFE}};

        tick(); tick();
        @(negedge clk); rst_n = 1'b1;
        tick();
        chk("rst_count", LW'(count), LW'(0));
        chk("rst_empty", LW'(empty), LW'(1));
        chk("rst_full", LW'(full), LW'(0));
        chk("rst_req", LW'(mem_wr_req), LW'(0));
        chk("rst_addr", LW'(mem_wr_addr), LW'(0));
        chk("rst_data", mem_wr_data, '0);

        // Reset while a request is outstanding
        evict(32'h0000_0060, aa);
        chk("midrst_req_before", LW'(mem_wr_req), LW'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req", LW'(mem_wr_req), LW'(0));
        chk("midrst_count", LW'(count), LW'(0));
        chk("midrst_empty", LW'(empty), LW'(1));
        @(posedge clk); @(negedge clk); rst_n = 1'b1;
        b = log_addr.size();
        mem_wr_ack = 1'b1;
        tick(); tick(); tick();
        mem_wr_ack = 1'b0;
        chk("midrst_no_write", LW'(log_addr.size()), LW'(b));

        // Single eviction with delayed ack
        evict(32'h0000_0040, aa);
        chk("single_req", LW'(mem_wr_req), LW'(1));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("single_hold_addr", LW'(mem_wr_addr), LW'(32'h40));
            chk("single_hold_data", mem_wr_data, aa);
        end
        mem_wr_ack = 1'b1;
        tick();
        mem_wr_ack = 1'b0;
        chk("single_empty", LW'(empty), LW'(1));
        chk("single_log", LW'(log_addr[log_addr.size()-1]), LW'(32'h40));

        // Fill, coalesce while full, refuse a new line while full
        evict(32'h0000_0000, d0);
        evict(32'h0000_0010, d1);
        evict(32'h0000_0020, d2);
        evict(32'h0000_0030, d3);
        chk("fill_count", LW'(count), LW'(4));
        chk("fill_full", LW'(full), LW'(1));
        in_addr = 32'h0000_0050; #1;
        chk("full_new_ready", LW'(in_ready), LW'(0));
        in_addr = 32'h0000_0020; #1;
        chk("full_coal_ready", LW'(in_ready), LW'(1));
        tick();
        evict(32'h0000_0020, d2n);
        chk("coal_count", LW'(count), LW'(4));
        lookup_addr = 32'h0000_0024; #1;
        chk("coal_lookup", lookup_data, d2n);
        evict(32'h0000_0050, f);
        chk("refused_count", LW'(count), LW'(4));
        b = log_addr.size();
        mem_wr_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b2b_writes", LW'(log_addr.size()), LW'(b + i + 1));
        end
        mem_wr_ack = 1'b0;
        chk("order0_a", LW'(log_addr[b]),   LW'(32'h00));
        chk("order0_d", log_data[b], d0);
        chk("order1_a", LW'(log_addr[b+1]), LW'(32'h10));
        chk("order1_d", log_data[b+1], d1);
        chk("order2_a", LW'(log_addr[b+2]), LW'(32'h20));
        chk("order2_d", log_data[b+2], d2n);
        chk("order3_a", LW'(log_addr[b+3]), LW'(32'h30));
        chk("order3_d", log_data[b+3], d3);
        chk("drain_empty", LW'(empty), LW'(1));

        // Same line evicted again while its first copy is in flight
        evict(32'h0000_0080, e1);
        evict(32'h0000_0080, e2);
        chk("dup_count", LW'(count), LW'(2));
        lookup_addr = 32'h0000_0084; #1;
        chk("dup_lk_hit", LW'(lookup_hit), LW'(1));
        chk("dup_lk_data", lookup_data, e2);
        b = log_addr.size();
        mem_wr_ack = 1'b1;
        tick();
        chk("dup_lk_after", lookup_data, e2);
        tick();
        mem_wr_ack = 1'b0;
        chk("dup_w0_a", LW'(log_addr[b]), LW'(32'h80));
        chk("dup_w0_d", log_data[b], e1);
        chk("dup_w1_a", LW'(log_addr[b+1]), LW'(32'h80));
        chk("dup_w1_d", log_data[b+1], e2);

        // Lookup with unaligned address, and a miss
        evict(32'h1234_5670, f);
        lookup_addr = 32'h1234_5678; #1;
        chk("lk_hit", LW'(lookup_hit), LW'(1));
        chk("lk_data", lookup_data, f);
        lookup_addr = 32'hDEAD_0000; #1;
        chk("lk_miss_hit", LW'(lookup_hit), LW'(0));
        chk("lk_miss_data", lookup_data, '0);
        mem_wr_ack = 1'b1;
        tick();

        // Streaming with ack held high
        b = log_addr.size();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_addr  = 32'h0000_0100 + 32'(i * 16);
            in_data  = {4{32'(i) + 32'h5500_0000}};
            #1;
            chk("stream_ready", LW'(in_ready), LW'(1));
            tick();
            chk("stream_count", LW'(count), LW'(1));
            chk("stream_writes", LW'(log_addr.size()), LW'(b + i));
        end
        in_valid = 1'b0;
        tick();
        mem_wr_ack = 1'b0;
        chk("stream_total", LW'(log_addr.size()), LW'(b + 8));
        chk("stream_last_a", LW'(log_addr[b+7]), LW'(32'h170));
        chk("stream_empty", LW'(empty), LW'(1));

        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
